// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two requesters, the round-robin arbiter and
// the shared sink. The arbiter connects through the slave modport; the
// surrounding producers/sink (or a bench) use the master modport.
interface mux2_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             sel;
    logic             busy;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, sel, busy
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, sel, busy
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 select path between requesters A
// and B, with a burst limit so a busy requester cannot starve the other.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no grant; one arbitration cycle, nothing is transferred
//   GNT_A | A owns the output path (sel=1)
//   GNT_B | B owns the output path (sel=0)
module mux2_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux2_rr_arbiter_if.slave     bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_A = 2'd1;
    localparam logic [1:0] GNT_B = 2'd2;

    // Count value of the last transfer allowed in a burst.
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    logic [1:0] state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;   // 1 = A was served most recently
    logic [7:0] cnt_q, cnt_d;

    logic       x_valid;
    logic       y_valid;
    logic       xfer;
    logic       burst_end;

    // Owner/other view of the requesters, so both grant states share one rule set.
    always_comb begin
        x_valid   = (state_q == GNT_A) ? bus.a_valid : bus.b_valid;
        y_valid   = (state_q == GNT_A) ? bus.b_valid : bus.a_valid;
        xfer      = (state_q != IDLE) && x_valid && bus.out_ready;
        burst_end = (cnt_q == BURST_LAST);
    end

    // Next-state, select, last-served and burst counter decision.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.a_valid && (!bus.b_valid || !last_q)) begin
                    state_d = GNT_A;
                    sel_d   = 1'b1;
                    last_d  = 1'b1;
                    cnt_d   = 8'd0;
                end else if (bus.b_valid) begin
                    state_d = GNT_B;
                    sel_d   = 1'b0;
                    last_d  = 1'b0;
                    cnt_d   = 8'd0;
                end
            end
            GNT_A, GNT_B: begin
                if (xfer) begin
                    if (burst_end) begin
                        cnt_d = 8'd0;
                        // Hand over with no bubble when the other side is waiting.
                        if (y_valid) begin
                            state_d = (state_q == GNT_A) ? GNT_B : GNT_A;
                            sel_d   = (state_q == GNT_B);
                            last_d  = (state_q == GNT_B);
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (!x_valid) begin
                    cnt_d = 8'd0;
                    if (y_valid) begin
                        state_d = (state_q == GNT_A) ? GNT_B : GNT_A;
                        sel_d   = (state_q == GNT_B);
                        last_d  = (state_q == GNT_B);
                    end else begin
                        state_d = IDLE;
                    end
                end
                // Backpressure with valid held: keep grant and count.
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; B counts as last served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_data  = sel_q ? bus.a_data : bus.b_data;
    assign bus.out_valid = (state_q == GNT_A) ? bus.a_valid :
                           (state_q == GNT_B) ? bus.b_valid : 1'b0;
    assign bus.a_ready   = (state_q == GNT_A) && bus.out_ready;
    assign bus.b_ready   = (state_q == GNT_B) && bus.out_ready;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q == GNT_A) || (state_q == GNT_B);

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a grant/burst reference model.
module tb_mux2_rr_arbiter;

    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux2_rr_arbiter_if #(.WIDTH(8)) bus ();

    mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic       ar;
        logic       br;
        logic       sel;
        logic       busy;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic av, input logic [7:0] ad,
                                input logic bv, input logic [7:0] bd,
                                input logic ordy, input logic ov,
                                input logic [7:0] od, input logic ar,
                                input logic br, input logic sel,
                                input logic busy);
        vec_t v;
        v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
        v.ov = ov; v.od = od; v.ar = ar; v.br = br; v.sel = sel; v.busy = busy;
        return v;
    endfunction

    function automatic logic [12:0] outs();
        return {bus.out_valid, bus.out_data, bus.a_ready, bus.b_ready, bus.sel, bus.busy};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {ov,od,ar,br,sel,busy}=%h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [7:0] ad, input logic bv,
                         input logic [7:0] bd, input logic ordy);
        bus.a_valid   = av;
        bus.a_data    = ad;
        bus.b_valid   = bv;
        bus.b_data    = bd;
        bus.out_ready = ordy;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Reference model: owner 0 = nobody, 1 = A, 2 = B.
    int   m_owner;
    int   m_served;
    logic m_last_a;
    logic m_sel;

    task automatic model_reset();
        m_owner  = 0;
        m_served = 0;
        m_last_a = 1'b0;
        m_sel    = 1'b0;
    endtask

    function automatic logic [12:0] model_outs();
        logic ov, ar, br;
        logic [7:0] od;
        ov = (m_owner == 1) ? bus.a_valid : (m_owner == 2) ? bus.b_valid : 1'b0;
        ar = (m_owner == 1) && bus.out_ready;
        br = (m_owner == 2) && bus.out_ready;
        od = m_sel ? bus.a_data : bus.b_data;
        return {ov, od, ar, br, m_sel, (m_owner != 0)};
    endfunction

    task automatic give(input int who);
        m_owner  = who;
        m_served = 0;
        m_last_a = (who == 1);
        m_sel    = (who == 1);
    endtask

    task automatic model_step(output logic acc_a, output logic acc_b);
        logic mine, other, moved;
        acc_a = 1'b0;
        acc_b = 1'b0;
        if (m_owner == 0) begin
            if (bus.a_valid && bus.b_valid) give(m_last_a ? 2 : 1);
            else if (bus.a_valid)           give(1);
            else if (bus.b_valid)           give(2);
        end else begin
            mine  = (m_owner == 1) ? bus.a_valid : bus.b_valid;
            other = (m_owner == 1) ? bus.b_valid : bus.a_valid;
            moved = mine && bus.out_ready;
            if (moved) begin
                if (m_owner == 1) acc_a = 1'b1; else acc_b = 1'b1;
                m_served = m_served + 1;
                if (m_served == MB) begin
                    m_served = 0;
                    if (other) give(3 - m_owner);
                end
            end else if (!mine) begin
                if (other) give(3 - m_owner);
                else begin
                    m_owner  = 0;
                    m_served = 0;
                end
            end
        end
    endtask

    initial begin
        logic acc_a, acc_b;
        logic ga;
        logic [7:0] rad, rbd;
        logic rav, rbv;

        tbl[0]  = mk(1, 8'h11, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0, 0);
        tbl[1]  = mk(1, 8'h11, 0, 8'h00, 1,  1, 8'h11, 1, 0, 1, 1);
        tbl[2]  = mk(1, 8'h22, 0, 8'h00, 1,  1, 8'h22, 1, 0, 1, 1);
        tbl[3]  = mk(1, 8'h33, 0, 8'h00, 1,  1, 8'h33, 1, 0, 1, 1);
        tbl[4]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 8'h00, 1, 0, 1, 1);
        tbl[5]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 8'h00, 0, 0, 1, 0);
        tbl[6]  = mk(1, 8'hA1, 0, 8'h00, 1,  0, 8'hA1, 0, 0, 1, 0);
        tbl[7]  = mk(1, 8'hA1, 1, 8'hB1, 1,  1, 8'hA1, 1, 0, 1, 1);
        tbl[8]  = mk(1, 8'hA2, 1, 8'hB1, 1,  1, 8'hA2, 1, 0, 1, 1);
        tbl[9]  = mk(0, 8'h00, 1, 8'hB1, 1,  0, 8'h00, 1, 0, 1, 1);
        tbl[10] = mk(0, 8'h00, 1, 8'hB1, 1,  1, 8'hB1, 0, 1, 0, 1);
        tbl[11] = mk(0, 8'h00, 1, 8'hB2, 1,  1, 8'hB2, 0, 1, 0, 1);
        tbl[12] = mk(0, 8'h00, 0, 8'h00, 1,  0, 8'h00, 0, 1, 0, 1);
        tbl[13] = mk(0, 8'h00, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0, 0);
        tbl[14] = mk(1, 8'hC1, 1, 8'hD1, 1,  0, 8'hD1, 0, 0, 0, 0);
        tbl[15] = mk(1, 8'hC1, 0, 8'h00, 1,  1, 8'hC1, 1, 0, 1, 1);
        tbl[16] = mk(0, 8'h00, 0, 8'h00, 1,  0, 8'h00, 1, 0, 1, 1);
        tbl[17] = mk(1, 8'hE1, 1, 8'hF1, 1,  0, 8'hE1, 0, 0, 1, 0);
        tbl[18] = mk(1, 8'hE1, 1, 8'hF1, 1,  1, 8'hF1, 0, 1, 0, 1);

        // Directed table: single-requester stream, drop-and-switch, ties.
        do_reset();
        #3;
        check("reset_state", outs(), {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].ordy);
            #3;
            check($sformatf("table_row%0d", i), outs(),
                  {tbl[i].ov, tbl[i].od, tbl[i].ar, tbl[i].br, tbl[i].sel, tbl[i].busy});
            step();
        end

        // Both requesters streaming: bursts of MB alternate with no bubble.
        do_reset();
        for (int c = 0; c < 25; c++) begin
            drive(1'b1, 8'(c), 1'b1, 8'(8'h80 + c), 1'b1);
            #3;
            if (c == 0) begin
                check("stream_arb", outs(), {1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0});
            end else begin
                ga = (((c - 1) / MB) % 2) == 0;
                check($sformatf("stream_c%0d", c), outs(),
                      {1'b1, (ga ? 8'(c) : 8'(8'h80 + c)), ga, !ga, ga, 1'b1});
            end
            step();
        end

        // Backpressure mid-burst: count must hold through the stall.
        do_reset();
        drive(1'b1, 8'h10, 1'b1, 8'h20, 1'b1);
        step();
        step();
        drive(1'b1, 8'h11, 1'b1, 8'h20, 1'b1);
        step();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 8'h12, 1'b1, 8'h20, 1'b0);
            #3;
            check($sformatf("stall_c%0d", c), outs(), {1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1});
            step();
        end
        drive(1'b1, 8'h12, 1'b1, 8'h20, 1'b1);
        #3;
        check("stall_rel0", outs(), {1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b1});
        step();
        drive(1'b1, 8'h13, 1'b1, 8'h20, 1'b1);
        #3;
        check("stall_rel1", outs(), {1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b1});
        step();
        #3;
        check("stall_to_b", outs(), {1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b1});
        step();

        // Reset in GNT_B at count 3, then a tie must go to A.
        do_reset();
        drive(1'b0, 8'h00, 1'b1, 8'h30, 1'b1);
        for (int c = 0; c < 4; c++) step();
        rst_n = 1'b1;
        #3;
        check("pre_rst_gntb", outs(), {1'b1, 8'h30, 1'b0, 1'b1, 1'b0, 1'b1});
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(1'b1, 8'h41, 1'b1, 8'h51, 1'b1);
        #3;
        check("post_rst_idle", outs(), {1'b0, 8'h51, 1'b0, 1'b0, 1'b0, 1'b0});
        step();
        #3;
        check("post_rst_tie_a", outs(), {1'b1, 8'h41, 1'b1, 1'b0, 1'b1, 1'b1});
        step();

        // Randomized run against the reference model, protocol-respecting producers.
        do_reset();
        model_reset();
        rav = 1'b0; rbv = 1'b0; rad = 8'h00; rbd = 8'h00;
        for (int c = 0; c < 600; c++) begin
            if (!rav && ($urandom_range(0, 2) != 0)) begin
                rav = 1'b1;
                rad = 8'($urandom_range(0, 255));
            end
            if (!rbv && ($urandom_range(0, 2) != 0)) begin
                rbv = 1'b1;
                rbd = 8'($urandom_range(0, 255));
            end
            drive(rav, rad, rbv, rbd, ($urandom_range(0, 3) != 0));
            #3;
            check($sformatf("rand_c%0d", c), outs(), model_outs());
            model_step(acc_a, acc_b);
            if (acc_a) rav = 1'b0;
            if (acc_b) rbv = 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 select path between two valid/ready requesters (A, B) and one downstream consumer.
- Owns the mux select as a registered FSM output. The data path is a plain 2:1 select: sel=1 passes A, sel=0 passes B.
- Adds burst-limited fairness: a requester keeps the grant for up to MAX_BURST transfers while the other is waiting.
- Sits between two producer blocks and a single shared sink/bus in lab datapaths.

Parameters:
- WIDTH, 8, data width of each requester and of the output.
- MAX_BURST, 4, max consecutive transfers per grant while the other requester is waiting. Legal range 1..255; counter is 8 bits.

Ports:
- clk  in  1  single system clock; everything is rising-edge.
- rst_n  in  1  reset, synchronous and active-low.
- a_valid  in  1  requester A has data.
- a_data  in  WIDTH  requester A data.
- a_ready  out  1  A transfer accepted this cycle.
- b_valid  in  1  requester B has data.
- b_data  in  WIDTH  requester B data.
- b_ready  out  1  B transfer accepted this cycle.
- out_valid  out  1  output data valid.
- out_data  out  WIDTH  selected data.
- out_ready  in  1  sink accepts.
- sel  out  1  registered mux select; 1 = A, 0 = B.
- busy  out  1  high in GNT_A or GNT_B.

Behaviour:
- Registers:
  - state ∈ {IDLE, GNT_A, GNT_B}
  - last (requester served most recently; 1 = A)
  - cnt[7:0]
- Reset (rst_n=0 at a clk edge, including mid-burst):
  - state=IDLE, sel=0, last=0 (B), so A wins the first tie. cnt=0.
  - Outputs settle next cycle to out_valid=0, a_ready=0, b_ready=0, busy=0.
  - A transfer in progress is abandoned; no partial handshake occurs in the reset cycle.
- Combinational outputs:
  - out_data = sel ? a_data : b_data
  - GNT_A: out_valid=a_valid, a_ready=out_ready, b_ready=0.
  - GNT_B: out_valid=b_valid, b_ready=out_ready, a_ready=0.
  - IDLE: out_valid, a_ready, b_ready all 0.
- Transfer: happens in a cycle where the granted requester's valid=1 and out_ready=1.
- IDLE transitions (one arbitration cycle; nothing is transferred in IDLE):
  - Only a_valid → GNT_A.
  - Only b_valid → GNT_B.
  - Both valid → grant the requester ≠ last.
  - Neither → stay in IDLE.
  - On entering a grant: sel updates with state, last is set to the granted requester, cnt=0.
- GNT_X transitions (Y = the other requester), priority order:
  1. Transfer and cnt==MAX_BURST-1 and y_valid → GNT_Y directly, no bubble; cnt=0, last=Y.
  2. Transfer and cnt==MAX_BURST-1 and !y_valid → stay; cnt=0.
  3. Transfer otherwise → stay; cnt=cnt+1.
  4. No transfer and x_valid=0 → GNT_Y if y_valid, else IDLE; cnt=0.
  5. No transfer and x_valid=1 (backpressure) → stay; cnt unchanged.
- Requesters must hold valid and data stable until accepted. The arbiter never revokes a grant while x_valid=1 and out_ready=0.
- Latency: first word reaches the output 1 cycle after valid rises from IDLE. Back-to-back transfers are 1 per cycle within a grant and across a burst-limit switch.
- A grant switch caused by requester X dropping valid (rule 4) costs one empty cycle: the cycle in which x_valid=0 is observed.
- MAX_BURST=1: grants alternate on every transfer while both requesters are valid.

Test Plan:
1. Reset, then a_valid=1 holding 3 words 0x11, 0x22, 0x33 with out_ready=1 → cycle 0 IDLE arbitration; out_data 0x11/0x22/0x33 on cycles 1-3 with a_ready=1 and sel=1; a_valid drops → IDLE, busy=0.
2. Both requesters valid continuously, MAX_BURST=4, out_ready=1 → A gets 4 transfers, then B gets 4, then A gets 4; no idle cycles after the first arbitration cycle; sel toggles every 4 cycles.
3. In GNT_A with cnt=2, out_ready=0 for 5 cycles → out_valid=1, out_data stable, cnt stays 2, b_ready=0; after release, A completes 2 more transfers before switching to B.
4. A sends 2 words then drops a_valid while b_valid=1 → one cycle with out_valid=0, then GNT_B with sel=0 and B data flowing.
5. Tie arbitration: first simultaneous request after reset → A granted; return to IDLE; second simultaneous request → B granted.
6. rst_n=0 for one cycle during GNT_B with cnt=3 → next cycle state=IDLE, sel=0, out_valid=0, a_ready=0, b_ready=0; a following tie → A granted.
